// File: rtl/mt9d111_axi_lite_master.sv
// Single-outstanding AXI4-Lite master: one command in, one single-beat write or read out, one response back.
// Optional watchdog: define MT9D111_AXI_LITE_MASTER_TIMEOUT_EN to build the sticky timeout_err counter.
module mt9d111_axi_lite_master #(
  parameter int C_M_AXI_LITE_ADDR_WIDTH = 9,
  parameter int C_M_AXI_LITE_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES          = 1024
) (
  input  logic                                 m_axi_lite_aclk,
  input  logic                                 reset,
  input  logic                                 cmd_valid,
  output logic                                 cmd_ready,
  input  logic                                 cmd_write,
  input  logic [C_M_AXI_LITE_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_LITE_DATA_WIDTH-1:0]   cmd_wdata,
  output logic                                 rsp_valid,
  input  logic                                 rsp_ready,
  output logic [C_M_AXI_LITE_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                           rsp_resp,
  output logic                                 m_axi_lite_awvalid,
  input  logic                                 m_axi_lite_awready,
  output logic [C_M_AXI_LITE_ADDR_WIDTH-1:0]   m_axi_lite_awaddr,
  output logic                                 m_axi_lite_wvalid,
  input  logic                                 m_axi_lite_wready,
  output logic [C_M_AXI_LITE_DATA_WIDTH-1:0]   m_axi_lite_wdata,
  output logic [C_M_AXI_LITE_DATA_WIDTH/8-1:0] m_axi_lite_wstrb,
  input  logic                                 m_axi_lite_bvalid,
  output logic                                 m_axi_lite_bready,
  input  logic [1:0]                           m_axi_lite_bresp,
  output logic                                 m_axi_lite_arvalid,
  input  logic                                 m_axi_lite_arready,
  output logic [C_M_AXI_LITE_ADDR_WIDTH-1:0]   m_axi_lite_araddr,
  input  logic                                 m_axi_lite_rvalid,
  output logic                                 m_axi_lite_rready,
  input  logic [C_M_AXI_LITE_DATA_WIDTH-1:0]   m_axi_lite_rdata,
  input  logic [1:0]                           m_axi_lite_rresp,
  output logic                                 busy,
  output logic                                 timeout_err,
  output logic [2:0]                           fsm_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_AW_W = 3'd1,
    WR_B    = 3'd2,
    RD_AR   = 3'd3,
    RD_R    = 3'd4,
    RSP     = 3'd5
  } state_t;

  // Every channel is valid/ready: a transfer happens on a rising edge where both are high;
  // a valid, once raised, is held with stable payload until that edge.
  state_t                               state;
  logic   [C_M_AXI_LITE_ADDR_WIDTH-1:0] addr_q;

  assign fsm_state         = state;
  assign m_axi_lite_awaddr = addr_q;
  assign m_axi_lite_araddr = addr_q;
  assign m_axi_lite_wstrb  = '1;

  always_ff @(posedge m_axi_lite_aclk) begin
    if (reset) begin
      state              <= IDLE;
      addr_q             <= '0;
      cmd_ready          <= 1'b0;
      busy               <= 1'b0;
      rsp_valid          <= 1'b0;
      rsp_rdata          <= '0;
      rsp_resp           <= 2'b00;
      m_axi_lite_awvalid <= 1'b0;
      m_axi_lite_wvalid  <= 1'b0;
      m_axi_lite_wdata   <= '0;
      m_axi_lite_bready  <= 1'b0;
      m_axi_lite_arvalid <= 1'b0;
      m_axi_lite_rready  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            addr_q           <= cmd_addr;
            m_axi_lite_wdata <= cmd_wdata;
            cmd_ready        <= 1'b0;
            busy             <= 1'b1;
            if (cmd_write) begin
              m_axi_lite_awvalid <= 1'b1;
              m_axi_lite_wvalid  <= 1'b1;
              state              <= WR_AW_W;
            end else begin
              m_axi_lite_arvalid <= 1'b1;
              state              <= RD_AR;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        WR_AW_W: begin
          // Address and data handshakes complete independently, in either order or together.
          if (m_axi_lite_awvalid && m_axi_lite_awready) m_axi_lite_awvalid <= 1'b0;
          if (m_axi_lite_wvalid && m_axi_lite_wready)   m_axi_lite_wvalid  <= 1'b0;
          if ((!m_axi_lite_awvalid || m_axi_lite_awready) &&
              (!m_axi_lite_wvalid  || m_axi_lite_wready)) begin
            m_axi_lite_bready <= 1'b1;
            state             <= WR_B;
          end
        end
        WR_B: begin
          if (m_axi_lite_bvalid) begin
            rsp_resp          <= m_axi_lite_bresp;
            rsp_rdata         <= '0;
            m_axi_lite_bready <= 1'b0;
            rsp_valid         <= 1'b1;
            state             <= RSP;
          end
        end
        RD_AR: begin
          if (m_axi_lite_arready) begin
            m_axi_lite_arvalid <= 1'b0;
            m_axi_lite_rready  <= 1'b1;
            state              <= RD_R;
          end
        end
        RD_R: begin
          if (m_axi_lite_rvalid) begin
            rsp_rdata         <= m_axi_lite_rdata;
            rsp_resp          <= m_axi_lite_rresp;
            m_axi_lite_rready <= 1'b0;
            rsp_valid         <= 1'b1;
            state             <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MT9D111_AXI_LITE_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t          prev_state;
  logic   [TW-1:0] timer;
  logic   [TW-1:0] cnt_next;
  logic            waiting;

  // The cycle of a state change counts as the first cycle in the new state.
  always_comb begin
    waiting  = (state == WR_AW_W) || (state == WR_B) || (state == RD_AR) || (state == RD_R);
    cnt_next = (state != prev_state) ? TW'(1) : timer + TW'(1);
  end

  always_ff @(posedge m_axi_lite_aclk) begin
    if (reset) begin
      prev_state  <= IDLE;
      timer       <= '0;
      timeout_err <= 1'b0;
    end else begin
      prev_state <= state;
      if (!waiting) begin
        timer <= '0;
      end else if ((state != prev_state) || (timer != TW'(TIMEOUT_CYCLES))) begin
        timer <= cnt_next;
        if (cnt_next == TW'(TIMEOUT_CYCLES)) timeout_err <= 1'b1;
      end
    end
  end
`else
  // Without the watchdog the limit has no effect; the flag is a constant zero.
  assign timeout_err = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_mt9d111_axi_lite_master.sv
// Directed and randomized bench for mt9d111_axi_lite_master with a response scoreboard.
module tb_mt9d111_axi_lite_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [8:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [8:0]  awaddr, araddr;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        busy, timeout_err;
  logic [2:0]  fsm_state;

  int vectors = 0;
  int miscompares = 0;
  logic [33:0] exp_q[$];

  always #5 clk = ~clk;

  mt9d111_axi_lite_master #(
    .C_M_AXI_LITE_ADDR_WIDTH(9),
    .C_M_AXI_LITE_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .m_axi_lite_aclk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axi_lite_awvalid(awvalid), .m_axi_lite_awready(awready), .m_axi_lite_awaddr(awaddr),
    .m_axi_lite_wvalid(wvalid), .m_axi_lite_wready(wready), .m_axi_lite_wdata(wdata),
    .m_axi_lite_wstrb(wstrb),
    .m_axi_lite_bvalid(bvalid), .m_axi_lite_bready(bready), .m_axi_lite_bresp(bresp),
    .m_axi_lite_arvalid(arvalid), .m_axi_lite_arready(arready), .m_axi_lite_araddr(araddr),
    .m_axi_lite_rvalid(rvalid), .m_axi_lite_rready(rready), .m_axi_lite_rdata(rdata),
    .m_axi_lite_rresp(rresp),
    .busy(busy), .timeout_err(timeout_err), .fsm_state(fsm_state)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic wr, input logic [8:0] a, input logic [31:0] d,
                          input logic [1:0] er, input logic [31:0] ed, input bit push);
    int c = 0;
    while (!cmd_ready && c < 20) begin step(); c++; end
    check("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    if (push) exp_q.push_back({er, ed});
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic collect_rsp(input int max_wait);
    logic [33:0] e;
    int c = 0;
    while (!rsp_valid && c < max_wait) begin step(); c++; end
    check("rsp_valid_wait", rsp_valid, 1);
    if (rsp_valid) begin
      check("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rsp", {rsp_resp, rsp_rdata}, e);
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
    end
  endtask

  task automatic clear_slave();
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
  endtask

  task automatic run_random(input int n);
    logic        wr, aw_pend, ar_pend;
    logic [8:0]  a;
    logic [31:0] d;
    logic [1:0]  r;
    for (int k = 0; k < n; k++) begin
      wr = 1'($urandom_range(0, 1));
      a  = 9'($urandom_range(0, 127) * 4);
      d  = $urandom();
      r  = 2'($urandom_range(0, 3));
      send_cmd(wr, a, d, r, wr ? 32'h0 : d, 1'b1);
      aw_pend = 1'b0; ar_pend = 1'b0;
      for (int c = 0; c < 60 && !rsp_valid; c++) begin
        if (aw_pend) check("aw_hold", {awvalid, awaddr, wdata}, {1'b1, a, d});
        if (ar_pend) check("ar_hold", {arvalid, araddr}, {1'b1, a});
        awready = 1'($urandom_range(0, 1));
        wready  = 1'($urandom_range(0, 1));
        arready = 1'($urandom_range(0, 1));
        bvalid  = bready & 1'($urandom_range(0, 1)); bresp = r;
        rvalid  = rready & 1'($urandom_range(0, 1)); rdata = d; rresp = r;
        aw_pend = awvalid & ~awready;
        ar_pend = arvalid & ~arready;
        step();
      end
      clear_slave();
      collect_rsp(1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    reset = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; rsp_ready = 0;
    clear_slave();
    repeat (3) step();
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_valids", {awvalid, wvalid, arvalid, rsp_valid}, 0);
    check("rst_readys", {bready, rready}, 0);
    check("rst_rsp", {rsp_resp, rsp_rdata}, 0);
    check("rst_busy_to", {busy, timeout_err}, 0);
    reset = 1'b0;
    step();
    check("post_rst_cmd_ready", cmd_ready, 1);

    // Zero-wait write
    awready = 1; wready = 1;
    send_cmd(1'b1, 9'h000, 32'h1A00_0000, 2'b00, 32'h0, 1'b1);
    check("w0_valids", {awvalid, wvalid}, 2'b11);
    check("w0_awaddr", awaddr, 9'h000);
    check("w0_wdata", wdata, 32'h1A00_0000);
    check("w0_wstrb", wstrb, 4'hF);
    check("w0_cmd_ready_busy", {cmd_ready, busy}, 2'b01);
    step();
    check("w0_bready", {bready, awvalid, wvalid}, 3'b100);
    step();
    check("w0_no_rsp_yet", rsp_valid, 0);
    bvalid = 1; bresp = 2'b00;
    step();
    check("w0_rsp_t4", {rsp_valid, bready}, 2'b10);
    clear_slave();
    collect_rsp(1);
    check("w0_idle_after", {cmd_ready, busy}, 2'b10);

    // Write with awready delayed 3 cycles, wready immediate
    wready = 1;
    send_cmd(1'b1, 9'h004, 32'h2, 2'b00, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("w1_aw_held", {awvalid, awaddr}, {1'b1, 9'h004});
      check("w1_wvalid", wvalid, (i == 0) ? 1 : 0);
      if (i == 3) awready = 1;
      step();
    end
    check("w1_to_b", {awvalid, wvalid, bready}, 3'b001);
    clear_slave();
    bvalid = 1;
    step();
    check("w1_rsp", {rsp_valid, bready}, 2'b10);
    clear_slave();
    collect_rsp(1);

    // Read with arready one cycle late and rvalid two cycles late
    send_cmd(1'b0, 9'h004, 32'h0, 2'b00, 32'h1, 1'b1);
    check("r0_ar", {arvalid, araddr}, {1'b1, 9'h004});
    step();
    check("r0_ar_held", arvalid, 1);
    arready = 1;
    step();
    check("r0_ar_drop", {arvalid, rready}, 2'b01);
    arready = 0;
    for (int i = 0; i < 2; i++) begin
      check("r0_r_wait", {rready, rsp_valid}, 2'b10);
      step();
    end
    rvalid = 1; rdata = 32'h1; rresp = 2'b00;
    step();
    check("r0_rsp", {rsp_valid, rready}, 2'b10);
    clear_slave();
    collect_rsp(1);

    // Zero-wait read with SLVERR and a stalled response consumer
    send_cmd(1'b0, 9'h010, 32'h0, 2'b10, 32'hDEAD_BEEF, 1'b1);
    check("r1_ar", arvalid, 1);
    arready = 1;
    step();
    check("r1_rready", {arvalid, rready}, 2'b01);
    arready = 0; rvalid = 1; rdata = 32'hDEAD_BEEF; rresp = 2'b10;
    step();
    clear_slave();
    for (int i = 0; i < 5; i++) begin
      check("r1_hold", {rsp_valid, rsp_resp, rsp_rdata, cmd_ready},
            {1'b1, 2'b10, 32'hDEAD_BEEF, 1'b0});
      step();
    end
    collect_rsp(1);

    // Reset while waiting for B; the command is dropped
    awready = 1; wready = 1;
    send_cmd(1'b1, 9'h008, 32'h55, 2'b00, 32'h0, 1'b0);
    step();
    check("rb_in_wr_b", bready, 1);
    clear_slave();
    reset = 1;
    step();
    check("rb_quiet", {awvalid, wvalid, bready, arvalid, rready, rsp_valid, busy, cmd_ready}, 0);
    reset = 0;
    step();
    check("rb_cmd_ready", cmd_ready, 1);

    run_random(12);

`ifdef MT9D111_AXI_LITE_MASTER_TIMEOUT_EN
    awready = 1; wready = 1;
    send_cmd(1'b1, 9'h00C, 32'h1, 2'b00, 32'h0, 1'b0);
    step();
    clear_slave();
    repeat (15) step();
    check("to_not_yet", timeout_err, 0);
    step();
    check("to_set", {timeout_err, bready}, 2'b11);
    repeat (4) step();
    check("to_sticky", {timeout_err, bready}, 2'b11);
    reset = 1;
    step();
    check("to_cleared", timeout_err, 0);
    reset = 0;
    step();
`else
    check("to_const0", timeout_err, 0);
`endif

    check("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mt9d111_axi_lite_master.md
# mt9d111_axi_lite_master

AXI4-Lite master that turns a simple one-command-at-a-time request interface into single-beat AXI4-Lite write and read transactions. It is the initiator counterpart of the camera interface's AXI Lite slave register file. A control sequencer uses it to program `fb_start_address`, trigger one-shot capture and read registers back. It allows one outstanding transaction and issues no bursts.

## Interface
Parameters:
- `C_M_AXI_LITE_ADDR_WIDTH`, 9, AXI address width.
- `C_M_AXI_LITE_DATA_WIDTH`, 32, AXI data width (only 32 supported).
- `TIMEOUT_CYCLES`, 1024, watchdog limit in aclk cycles (used only with the macro).

Ports:
- `m_axi_lite_aclk` in 1: the single clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `cmd_valid` in 1, `cmd_ready` out 1, `cmd_write` in 1 (1 = write), `cmd_addr` in ADDR_WIDTH, `cmd_wdata` in 32: command channel.
- `rsp_valid` out 1, `rsp_ready` in 1, `rsp_rdata` out 32, `rsp_resp` out 2: response channel.
- AXI write channels:
  - `m_axi_lite_awvalid` out, `m_axi_lite_awready` in, `m_axi_lite_awaddr` out ADDR_WIDTH
  - `m_axi_lite_wvalid` out, `m_axi_lite_wready` in, `m_axi_lite_wdata` out 32, `m_axi_lite_wstrb` out 4 (constant 4'hF)
  - `m_axi_lite_bvalid` in, `m_axi_lite_bready` out, `m_axi_lite_bresp` in 2
- AXI read channels:
  - `m_axi_lite_arvalid` out, `m_axi_lite_arready` in, `m_axi_lite_araddr` out ADDR_WIDTH
  - `m_axi_lite_rvalid` in, `m_axi_lite_rready` out, `m_axi_lite_rdata` in 32, `m_axi_lite_rresp` in 2
- `busy` out 1: high in any state other than IDLE.
- `timeout_err` out 1: sticky watchdog flag (macro only; otherwise tied 0).

## Operation
- States: IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`, latch addr/wdata/write flag.
  - Write goes to WR_AW_W with awvalid=1 and wvalid=1.
  - Read goes to RD_AR with arvalid=1.
- WR_AW_W:
  - awvalid and wvalid are tracked independently.
  - Each drops the cycle after its own ready is sampled high.
  - When both have completed (including both completing in the same cycle), go to WR_B with bready=1.
- WR_B: on bvalid, capture bresp into `rsp_resp`, set `rsp_rdata`=0, drop bready, go to RSP.
- RD_AR: on arready, drop arvalid, raise rready, go to RD_R.
- RD_R: on rvalid, capture rdata/rresp, drop rready, go to RSP.
- RSP: `rsp_valid`=1 and the response is held stable until `rsp_ready`, then go to IDLE.
- Address and data outputs are stable while their valid is high. A valid is never dropped before its ready.
- Reset values: all valids and readys 0, `cmd_ready`=0 during reset, `rsp_valid`=0, `rsp_rdata`=0, `rsp_resp`=2'b00, `busy`=0, `timeout_err`=0, state=IDLE.
- Reset mid-transaction: everything returns to IDLE and the command is lost. The slave is reset by the same source.

## Timing
- `cmd_ready` is a registered decode of IDLE. The cycle after acceptance it is 0.
- Zero-wait slave write (awready=wready=1, bvalid the cycle after bready):
  - cmd accept at T.
  - aw/w valid at T+1.
  - bready at T+2.
  - rsp_valid at T+4.
- Zero-wait slave read: cmd at T, arvalid at T+1, rready at T+2, rsp_valid at T+3 when rvalid is already high.
- `rsp_ready` held high: back-to-back commands are accepted on the cycle after rsp handshake (IDLE for one cycle).
- No combinational path from any AXI input to any AXI output.

## Configuration
- `MT9D111_AXI_LITE_MASTER_TIMEOUT_EN` defined:
  - A counter runs in WR_AW_W, WR_B, RD_AR and RD_R.
  - It reloads on each state change.
  - Reaching `TIMEOUT_CYCLES` sets `timeout_err`, which stays set until `reset`.
  - The transaction keeps waiting; no AXI rule is violated.
- Macro undefined: no counter logic is built, and `timeout_err` is constant 0.

## Test plan
- Write 0x000 ← 0x1A00_0000 with a zero-wait slave → aw/w valid at T+1, awaddr=0x000, wdata=0x1A000000, wstrb=4'hF, rsp_valid at T+4, rsp_resp=00.
- Write 0x004 ← 0x2, with awready delayed 3 cycles and wready 0 cycles → wvalid drops after 1 cycle, awvalid held 4 cycles, single B, rsp_resp=00.
- Read 0x004 with a slave that returns 0x1 with rvalid 2 cycles late → rsp_rdata=0x1, rsp_resp=00, arvalid high exactly until arready.
- Read with rresp=2'b10, then rsp_ready held low 5 cycles → rsp_valid/rsp_resp=10 stable for 5 cycles, cmd_ready stays 0.
- Reset asserted in WR_B → next cycle all valids/readys 0, busy=0, and one cycle after reset release cmd_ready=1.
- Macro on, TIMEOUT_CYCLES=16, bvalid never asserted → timeout_err=1 after 16 cycles in WR_B, bready still 1, flag persists until reset.
